// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment reader: segment codes, result classes, FSM states.
// Bit order of every code is {g,f,e,d,c,b,a} = bit6..bit0.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    CLS_DIGIT   = 2'd0,
    CLS_BLANK   = 2'd1,
    CLS_INVALID = 2'd2
  } cls_t;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOAD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_reader_if.sv
// Result channel of the 7-segment reader: valid/ready handshake plus decoded symbol fields.
// The reader drives the master side; the consumer drives out_ready.
interface seg7_reader_if;
  import seg7_pkg::*;

  logic       out_valid;
  logic       out_ready;
  cls_t       out_class;
  logic [3:0] out_digit;
  logic [6:0] out_pattern;

  modport master (
    output out_valid, out_class, out_digit, out_pattern,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_class, out_digit, out_pattern,
    output out_ready
  );

endinterface

// File: rtl/seg7_classify.sv
// Combinational pattern classifier: 7-segment code -> {DIGIT 0-9, BLANK, INVALID}.
// Digit output is forced to 0 for anything that is not a digit.
module seg7_classify
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output cls_t       cls,
  output logic [3:0] digit
);

  always_comb begin
    cls   = CLS_DIGIT;
    digit = 4'd0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: cls   = CLS_BLANK;
      default:   cls   = CLS_INVALID;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Samples a 7-segment bus, accepts a pattern after STABLE_CYCLES stable edges and reports each new symbol.
// Result appears STABLE_CYCLES edges after capture; a result arriving while one is stalled is dropped (overrun).
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [6:0]       segments_in,
  input  logic             clr_stats,
  seg7_reader_if.master    res,
  output logic             overrun,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [3:0]       STAB_MAX = 4'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t     state, state_nxt;
  logic [6:0] seg_q;
  logic [6:0] last_acc;
  logic [3:0] stab_cnt;
  logic       first;

  logic       same;
  logic       accept;
  logic       produce;
  logic       load;
  cls_t       cls;
  logic [3:0] digit;

  assign same = (segments_in == seg_q);

  seg7_classify u_classify (
    .pattern (seg_q),
    .cls     (cls),
    .digit   (digit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_WAIT;
    else     state <= state_nxt;
  end

  // Acceptance is folded into the SETTLE exit edge, so LOAD is never occupied.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    if (!en) begin
      state_nxt = ST_WAIT;
    end else if (!same) begin
      state_nxt = ST_SETTLE;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (stab_cnt == STAB_MAX) begin
            accept    = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
        ST_LOAD:  state_nxt = ST_WAIT;
        default:  state_nxt = ST_WAIT;
      endcase
    end
  end

  // A pattern that settles back onto the last reported one is swallowed.
  assign produce = accept && (first || (seg_q != last_acc));
  assign load    = produce && (!res.out_valid || res.out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q    <= 7'd0;
      stab_cnt <= 4'd0;
      last_acc <= 7'd0;
      first    <= 1'b1;
    end else begin
      if (en) begin
        seg_q <= segments_in;
        if (!same)
          stab_cnt <= 4'd0;
        else if (stab_cnt != STAB_MAX)
          stab_cnt <= stab_cnt + 4'd1;
      end
      if (produce) begin
        last_acc <= seg_q;
        first    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res.out_valid   <= 1'b0;
      res.out_class   <= CLS_DIGIT;
      res.out_digit   <= 4'd0;
      res.out_pattern <= 7'd0;
    end else if (load) begin
      res.out_valid   <= 1'b1;
      res.out_class   <= cls;
      res.out_digit   <= digit;
      res.out_pattern <= seg_q;
    end else if (res.out_valid && res.out_ready) begin
      res.out_valid   <= 1'b0;
    end
  end

  // Dropped INVALID results still count as errors; clear beats any same-edge increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      err_count <= '0;
    end else if (clr_stats) begin
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      if (produce && !load)
        overrun <= 1'b1;
      if (produce && (cls == CLS_INVALID) && (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: two instances (STABLE_CYCLES=4 and 1) share stimulus and are
// compared every cycle against a run-length model, with literal expectations at key points.
module tb_seg7_reader;
  import seg7_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, clr_stats, out_ready;
  logic [6:0] segments_in;
  logic       ovr0, ovr1;
  logic [7:0] err0, err1;

  always #5 clk = ~clk;

  seg7_reader_if if0 ();
  seg7_reader_if if1 ();
  assign if0.out_ready = out_ready;
  assign if1.out_ready = out_ready;

  seg7_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .en(en), .segments_in(segments_in), .clr_stats(clr_stats),
    .res(if0), .overrun(ovr0), .err_count(err0)
  );

  seg7_reader #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .en(en), .segments_in(segments_in), .clr_stats(clr_stats),
    .res(if1), .overrun(ovr1), .err_count(err1)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks how long the current input has been presented since it last changed.
  typedef struct {
    logic [6:0] prev;
    int         held;
    bit         pending;
    logic [6:0] last;
    bit         first;
    bit         vld;
    logic [1:0] cls;
    logic [3:0] dig;
    logic [6:0] pat;
    bit         ovr;
    int         err;
  } mdl_t;

  mdl_t m[2];
  int   stab[2] = '{4, 1};

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.prev = 7'd0; r.held = 0; r.pending = 0; r.last = 7'd0; r.first = 1;
    r.vld = 0; r.cls = 2'd0; r.dig = 4'd0; r.pat = 7'd0; r.ovr = 0; r.err = 0;
    return r;
  endfunction

  function automatic void classify(input logic [6:0] p, output logic [1:0] c, output logic [3:0] d);
    logic [6:0] codes [10];
    codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    c = (p == 7'h00) ? 2'd1 : 2'd2;
    d = 4'd0;
    for (int k = 0; k < 10; k++)
      if (codes[k] == p) begin
        c = 2'd0;
        d = 4'(k);
      end
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input int stable);
    bit         prod = 0;
    logic [1:0] c;
    logic [3:0] d;
    if (en) begin
      if (segments_in != s.prev) begin
        s.held    = 0;
        s.pending = 1;
      end else begin
        s.held++;
        if (s.pending && s.held >= stable) begin
          s.pending = 0;
          if (s.first || segments_in != s.last) begin
            prod    = 1;
            s.last  = segments_in;
            s.first = 0;
          end
        end
      end
      s.prev = segments_in;
    end else begin
      s.pending = 0;
    end
    if (prod) begin
      classify(segments_in, c, d);
      if (c == 2'd2 && s.err < 255) s.err++;
      if (!s.vld || out_ready) begin
        s.vld = 1; s.cls = c; s.dig = d; s.pat = segments_in;
      end else begin
        s.ovr = 1;
      end
    end else if (s.vld && out_ready) begin
      s.vld = 0;
    end
    if (clr_stats) begin
      s.ovr = 0;
      s.err = 0;
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      m[i] = rst ? mdl_reset() : mdl_step(m[i], stab[i]);
    @(negedge clk);
  endtask

  task automatic cmp_dut(input string tag, input mdl_t s, input logic v, input logic [1:0] c,
                         input logic [3:0] d, input logic [6:0] p, input logic o, input logic [7:0] e);
    chk({tag, ".valid"},   32'(v), 32'(s.vld));
    chk({tag, ".class"},   32'(c), 32'(s.cls));
    chk({tag, ".digit"},   32'(d), 32'(s.dig));
    chk({tag, ".pattern"}, 32'(p), 32'(s.pat));
    chk({tag, ".overrun"}, 32'(o), 32'(s.ovr));
    chk({tag, ".err"},     32'(e), 32'(s.err));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("d0", m[0], if0.out_valid, if0.out_class, if0.out_digit, if0.out_pattern, ovr0, err0);
      cmp_dut("d1", m[1], if1.out_valid, if1.out_class, if1.out_digit, if1.out_pattern, ovr1, err1);
    end
  end

  initial begin
    rst = 1'b0; en = 1'b1; clr_stats = 1'b0; out_ready = 1'b1; segments_in = 7'h00;
    m[0] = mdl_reset();
    m[1] = mdl_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.valid",   32'(if0.out_valid),   32'd0);
    chk("rst.pattern", 32'(if0.out_pattern), 32'd0);
    chk("rst.err",     32'(err0),            32'd0);
    rst = 1'b0;
    chk_en = 1;

    // Single stable digit: result exactly on the fourth edge after capture, once.
    segments_in = 7'h5B;
    repeat (4) step();
    chk("t1.early",   32'(if0.out_valid),   32'd0);
    step();
    chk("t1.valid",   32'(if0.out_valid),   32'd1);
    chk("t1.class",   32'(if0.out_class),   32'd0);
    chk("t1.digit",   32'(if0.out_digit),   32'd2);
    chk("t1.pattern", 32'(if0.out_pattern), 32'h5B);
    step();
    chk("t1.norepeat", 32'(if0.out_valid),  32'd0);
    repeat (4) step();

    // Short glitch of digit 1 is filtered; digit 3 follows.
    segments_in = 7'h06;
    repeat (2) step();
    segments_in = 7'h4F;
    repeat (4) step();
    chk("t2.noglitch", 32'(if0.out_valid), 32'd0);
    step();
    chk("t2.digit",   32'(if0.out_digit),   32'd3);
    step();

    // INVALID and BLANK classification, then statistics clear.
    segments_in = 7'h01;
    repeat (5) step();
    chk("t3.inv.class", 32'(if0.out_class), 32'd2);
    chk("t3.inv.err",   32'(err0),          32'd1);
    segments_in = 7'h00;
    repeat (5) step();
    chk("t3.blank.class", 32'(if0.out_class), 32'd1);
    chk("t3.blank.digit", 32'(if0.out_digit), 32'd0);
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("t3.clr.err", 32'(err0), 32'd0);

    // Stalled consumer: second result dropped, overrun sticks.
    out_ready = 1'b0;
    segments_in = 7'h66;
    repeat (6) step();
    segments_in = 7'h6D;
    repeat (6) step();
    chk("t4.held.digit", 32'(if0.out_digit), 32'd4);
    chk("t4.overrun",    32'(ovr0),          32'd1);
    out_ready = 1'b1;
    step();
    chk("t4.drain", 32'(if0.out_valid), 32'd0);

    // Disabled sampling ignores input; a settle interrupted by en=0 is lost.
    en = 1'b0;
    segments_in = 7'h3F;
    repeat (6) step();
    chk("en.off", 32'(if0.out_valid), 32'd0);
    en = 1'b1;
    repeat (5) step();
    chk("en.on.digit", 32'(if0.out_digit), 32'd0);
    chk("en.on.valid", 32'(if0.out_valid), 32'd1);
    step();
    segments_in = 7'h07;
    repeat (2) step();
    en = 1'b0;
    step();
    en = 1'b1;
    repeat (6) step();
    chk("en.lost", 32'(if0.out_valid), 32'd0);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      segments_in = i[0] ? 7'h01 : 7'h02;
      repeat (5) step();
    end
    chk("sat.err", 32'(err0), 32'd255);
    step();

    // Asynchronous reset with a pending result and a settle in progress.
    out_ready = 1'b0;
    segments_in = 7'h6F;
    repeat (5) step();
    chk("t5.pre.digit", 32'(if0.out_digit), 32'd9);
    segments_in = 7'h7F;
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    chk("t5.rst.valid",   32'(if0.out_valid),   32'd0);
    chk("t5.rst.digit",   32'(if0.out_digit),   32'd0);
    chk("t5.rst.pattern", 32'(if0.out_pattern), 32'd0);
    chk("t5.rst.overrun", 32'(ovr0),            32'd0);
    chk("t5.rst.err",     32'(err0),            32'd0);
    m[0] = mdl_reset();
    m[1] = mdl_reset();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("t5.early", 32'(if0.out_valid), 32'd0);
    step();
    chk("t5.digit",   32'(if0.out_digit),   32'd8);
    chk("t5.pattern", 32'(if0.out_pattern), 32'h7F);

    // Single-edge filter instance: consecutive digits 0,1,2.
    segments_in = 7'h3F;
    repeat (2) step();
    chk("t6.d0", 32'({if1.out_valid, if1.out_digit}), 32'h10);
    segments_in = 7'h06;
    repeat (2) step();
    chk("t6.d1", 32'({if1.out_valid, if1.out_digit}), 32'h11);
    segments_in = 7'h5B;
    repeat (2) step();
    chk("t6.d2", 32'({if1.out_valid, if1.out_digit}), 32'h12);
    repeat (6) step();

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
